// File: rtl/vblank_access_arbiter.sv
// Round-robin time-slicing of a shared memory bus among NUM_CLIENTS requesters during vertical blanking.
// ce/busy/slot_done are registered; a request seen in SCAN gets its ce one cycle later.
module vblank_access_arbiter #(
   parameter int NUM_CLIENTS  = 4,
   parameter int SLOT_CYCLES  = 4752,
   parameter int CNT_W        = 13,
   parameter int POS_W        = 10,
   parameter int VBLANK_START = 480
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [POS_W-1:0]               shpos,
   input  logic [POS_W-1:0]               svpos,
   input  logic [NUM_CLIENTS-1:0]         req,
   output logic [NUM_CLIENTS-1:0]         ce,
   output logic [$clog2(NUM_CLIENTS)-1:0] grant_idx,
   output logic                           busy,
   output logic                           slot_done
);

   localparam int IDX_W = $clog2(NUM_CLIENTS);

   typedef enum logic [1:0] {IDLE, SCAN, ACTIVE} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [IDX_W-1:0]       last, last_nxt, grant_nxt, pick_idx;
   logic [NUM_CLIENTS-1:0] ce_nxt;
   logic                   busy_nxt, done_nxt, vblank, pick_vld, slot_end;
   logic                   unused_shpos;

   assign unused_shpos = ^shpos;
   assign vblank       = (svpos >= POS_W'(VBLANK_START));
   assign pick_vld     = |req;
   assign slot_end     = (cnt == CNT_W'(SLOT_CYCLES - 1)) || !req[grant_idx];

   // Walk downward so the candidate nearest after last is the one that sticks.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand     = '0;
      pick_idx = '0;
      for (int k = NUM_CLIENTS; k >= 1; k--) begin
         cand = IDX_W'((int'(last) + k) % NUM_CLIENTS);
         if (req[cand]) pick_idx = cand;
      end
   end

   always_comb begin
      state_nxt = state;
      ce_nxt    = ce;
      grant_nxt = grant_idx;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      cnt_nxt   = cnt;
      last_nxt  = last;
      unique case (state)
         IDLE: begin
            ce_nxt   = '0;
            busy_nxt = 1'b0;
            cnt_nxt  = '0;
            if (vblank) state_nxt = SCAN;
         end
         SCAN: begin
            ce_nxt   = '0;
            busy_nxt = 1'b0;
            if (!vblank) begin
               state_nxt = IDLE;
            end else if (pick_vld) begin
               ce_nxt    = NUM_CLIENTS'(1) << pick_idx;
               grant_nxt = pick_idx;
               busy_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            // Leaving vblank wins over a coincident slot end: abort, no pulse.
            if (!vblank) begin
               state_nxt = IDLE;
               ce_nxt    = '0;
               busy_nxt  = 1'b0;
               cnt_nxt   = '0;
               last_nxt  = grant_idx;
            end else if (slot_end) begin
               state_nxt = SCAN;
               ce_nxt    = '0;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               last_nxt  = grant_idx;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ce        <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
         slot_done <= 1'b0;
         cnt       <= '0;
         last      <= IDX_W'(NUM_CLIENTS - 1);
      end else begin
         state     <= state_nxt;
         ce        <= ce_nxt;
         grant_idx <= grant_nxt;
         busy      <= busy_nxt;
         slot_done <= done_nxt;
         cnt       <= cnt_nxt;
         last      <= last_nxt;
      end
   end

endmodule

// File: tb/tb_vblank_access_arbiter.sv
// Directed bench for vblank_access_arbiter: 4 clients, 8-cycle slots, vblank from line 480.
module tb_vblank_access_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] shpos, svpos;
   logic [3:0] req;
   logic [3:0] ce;
   logic [1:0] grant_idx;
   logic       busy, slot_done;
   int         total = 0;
   int         bad = 0;

   vblank_access_arbiter #(
      .NUM_CLIENTS(4), .SLOT_CYCLES(8), .CNT_W(4), .POS_W(10), .VBLANK_START(480)
   ) dut (
      .clk(clk), .reset(reset), .shpos(shpos), .svpos(svpos), .req(req),
      .ce(ce), .grant_idx(grant_idx), .busy(busy), .slot_done(slot_done)
   );

   always #5 clk = ~clk;

   task tick;
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a grant, then measures how long that ce pattern is held.
   task automatic observe_slot(output logic [3:0] o_ce, output logic [1:0] o_idx,
                               output logic o_busy, output int o_wait, output int o_len,
                               output logic o_done, output logic [3:0] o_after);
      o_wait = 0;
      while (ce == 4'b0 && o_wait < 64) begin tick(); o_wait++; end
      o_ce = ce; o_idx = grant_idx; o_busy = busy; o_len = 0;
      while (ce == o_ce && ce != 4'b0 && o_len < 64) begin tick(); o_len++; end
      o_done = slot_done; o_after = ce;
   endtask

   task test_reset;
      reset = 1'b1; req = 4'b1111; svpos = 10'd479; shpos = 10'd0;
      tick(); tick();
      total++; if (ce !== 4'b0)      begin bad++; $display("FAIL reset_ce got=%b exp=0000", ce); end
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (slot_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", slot_done); end
      total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
      reset = 1'b0;
      tick();
      total++; if (ce !== 4'b0) begin bad++; $display("FAIL idle_no_vblank got=%b exp=0000", ce); end
   endtask

   task test_round_robin;
      logic [3:0] exp_ce [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] g, a; logic [1:0] gi; logic b, d; int w, l;
      svpos = 10'd480;
      tick();
      total++; if (ce !== 4'b0) begin bad++; $display("FAIL scan_first_cycle got=%b exp=0000", ce); end
      for (int i = 0; i < 5; i++) begin
         observe_slot(g, gi, b, w, l, d, a);
         total++; if (g !== exp_ce[i] || gi !== exp_idx[i] || b !== 1'b1)
            begin bad++; $display("FAIL rr_grant%0d ce=%b idx=%0d busy=%b exp ce=%b idx=%0d busy=1", i, g, gi, b, exp_ce[i], exp_idx[i]); end
         total++; if (w != 1 || l != 8)
            begin bad++; $display("FAIL rr_timing%0d wait=%0d len=%0d exp wait=1 len=8", i, w, l); end
         total++; if (d !== 1'b1 || a !== 4'b0)
            begin bad++; $display("FAIL rr_end%0d done=%b ce=%b exp done=1 ce=0000", i, d, a); end
      end
   endtask

   task test_sparse_req;
      logic [3:0] exp_ce [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
      logic [3:0] g, a; logic [1:0] gi; logic b, d; int w, l;
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         observe_slot(g, gi, b, w, l, d, a);
         total++; if (g !== exp_ce[i] || l != 8 || d !== 1'b1)
            begin bad++; $display("FAIL sparse%0d ce=%b len=%0d done=%b exp ce=%b len=8 done=1", i, g, l, d, exp_ce[i]); end
      end
   endtask

   task test_early_release;
      logic [3:0] g, a; logic [1:0] gi; logic b, d; int w, l;
      req = 4'b1100;
      tick();
      total++; if (ce !== 4'b0100) begin bad++; $display("FAIL early_grant got=%b exp=0100", ce); end
      tick(); tick();
      req = 4'b1000;
      tick();
      total++; if (ce !== 4'b0 || slot_done !== 1'b1 || busy !== 1'b0)
         begin bad++; $display("FAIL early_drop ce=%b done=%b busy=%b exp ce=0000 done=1 busy=0", ce, slot_done, busy); end
      tick();
      total++; if (ce !== 4'b1000 || slot_done !== 1'b0 || grant_idx !== 2'd3)
         begin bad++; $display("FAIL early_next ce=%b done=%b idx=%0d exp ce=1000 done=0 idx=3", ce, slot_done, grant_idx); end
      observe_slot(g, gi, b, w, l, d, a);
      total++; if (w != 0 || l != 8 || d !== 1'b1)
         begin bad++; $display("FAIL early_client3 wait=%0d len=%0d done=%b exp wait=0 len=8 done=1", w, l, d); end
   endtask

   task test_abort;
      logic [3:0] g, a; logic [1:0] gi; logic b, d; int w, l;
      req = 4'b1111;
      tick();
      total++; if (ce !== 4'b0001) begin bad++; $display("FAIL abort_grant got=%b exp=0001", ce); end
      for (int i = 0; i < 5; i++) tick();
      total++; if (ce !== 4'b0001) begin bad++; $display("FAIL abort_hold got=%b exp=0001", ce); end
      svpos = 10'd0;
      tick();
      total++; if (ce !== 4'b0 || busy !== 1'b0 || slot_done !== 1'b0)
         begin bad++; $display("FAIL abort_drop ce=%b busy=%b done=%b exp 0000 0 0", ce, busy, slot_done); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (ce !== 4'b0 || slot_done !== 1'b0)
            begin bad++; $display("FAIL abort_idle%0d ce=%b done=%b exp ce=0000 done=0", i, ce, slot_done); end
      end
      svpos = 10'd480;
      observe_slot(g, gi, b, w, l, d, a);
      total++; if (g !== 4'b0010 || w != 2 || l != 8)
         begin bad++; $display("FAIL abort_resume ce=%b wait=%0d len=%0d exp ce=0010 wait=2 len=8", g, w, l); end
   endtask

   task test_no_request;
      req = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++; if (ce !== 4'b0 || busy !== 1'b0 || slot_done !== 1'b0)
            begin bad++; $display("FAIL noreq%0d ce=%b busy=%b done=%b exp 0000 0 0", i, ce, busy, slot_done); end
      end
      req = 4'b1000;
      tick();
      total++; if (ce !== 4'b1000 || grant_idx !== 2'd3 || busy !== 1'b1)
         begin bad++; $display("FAIL late_req ce=%b idx=%0d busy=%b exp ce=1000 idx=3 busy=1", ce, grant_idx, busy); end
   endtask

   task test_async_reset;
      logic [3:0] g, a; logic [1:0] gi; logic b, d; int w, l;
      tick(); tick();
      #3;
      reset = 1'b1;
      #1;
      total++; if (ce !== 4'b0 || busy !== 1'b0)
         begin bad++; $display("FAIL async_reset ce=%b busy=%b exp ce=0000 busy=0", ce, busy); end
      tick();
      reset = 1'b0; req = 4'b1111;
      observe_slot(g, gi, b, w, l, d, a);
      total++; if (g !== 4'b0001 || gi !== 2'd0 || w != 2 || l != 8)
         begin bad++; $display("FAIL post_reset ce=%b idx=%0d wait=%0d len=%0d exp ce=0001 idx=0 wait=2 len=8", g, gi, w, l); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_sparse_req();
      test_early_release();
      test_abort();
      test_no_request();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
